// File: rtl/data_sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_bridge_pkg
// Shared definitions for the M-stage data SRAM bridge:
//   - state_t   : bridge FSM encoding (IDLE=0, REQ=1, WAIT=2, DONE=3)
//   - SZ_*      : bus_size encodings (byte / half / word)
//   - KSEG_MASK : kseg0/kseg1 virtual-to-physical mask, used only when the
//                 KSEG_MAP_EN macro is defined
// -----------------------------------------------------------------------------
package data_sram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/data_sram_bridge_dbus_fmt.sv
// -----------------------------------------------------------------------------
// dbus_fmt
// Combinational request formatter. Turns the core's byte write enables and
// effective address into the bus write flag, transfer size, formatted address
// and strobes.
//   Optional macro: KSEG_MAP_EN -- when defined, formatted addresses in
//   0x8000_0000..0xBFFF_FFFF are ANDed with KSEG_MASK.
// Ports:
//   wen      in  4       byte write enables (0000 = read)
//   addr     in  ADDR_W  effective address from the core
//   wr       out 1       1 = write
//   size     out 2       SZ_BYTE / SZ_HALF / SZ_WORD
//   fmt_addr out ADDR_W  formatted (and optionally mapped) bus address
//   strb     out 4       bus byte strobes
// -----------------------------------------------------------------------------
module dbus_fmt
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] fmt_addr,
    output logic [3:0]        strb
);

    logic [1:0] low;

    always_comb begin
        wr       = |wen;
        size     = SZ_WORD;
        low      = 2'b00;
        strb     = wen;
        // Reads are always full-word; lane extraction happens downstream.
        if (wr) begin
            case (wen)
                4'b1111: begin size = SZ_WORD; low = 2'b00; end
                4'b0011: begin size = SZ_HALF; low = 2'b00; end
                4'b1100: begin size = SZ_HALF; low = 2'b10; end
                4'b0001: begin size = SZ_BYTE; low = 2'b00; end
                4'b0010: begin size = SZ_BYTE; low = 2'b01; end
                4'b0100: begin size = SZ_BYTE; low = 2'b10; end
                4'b1000: begin size = SZ_BYTE; low = 2'b11; end
                // Irregular patterns go out as a word with strobes untouched.
                default: begin size = SZ_WORD; low = 2'b00; end
            endcase
        end
        fmt_addr = {addr[ADDR_W-1:2], low};
`ifdef KSEG_MAP_EN
        // kseg0/kseg1 have top bits 10; both alias the low 512 MB.
        if (fmt_addr[ADDR_W-1 -: 2] == 2'b10) begin
            fmt_addr = fmt_addr & ADDR_W'(KSEG_MASK);
        end
`endif
    end

endmodule

// File: rtl/data_sram_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_bridge
// M-stage data-access bridge: converts the core's load/store request into a
// split-handshake SRAM-like bus (req / addr_ok / data_ok) and stalls the
// pipeline until the access completes.
//   Optional macro: KSEG_MAP_EN (kseg0/kseg1 address mapping, see dbus_fmt).
// Handshake: bus_req is held high with stable addr/size/strb/wdata until a
// cycle with bus_addr_ok=1; the response is the first later cycle with
// bus_data_ok=1, carrying bus_rdata for loads. There is no abort.
// Ports:
//   clk, rst (async, active-low)
//   cpu_req, cpu_wen[3:0], cpu_addr, cpu_wdata, cpu_hold  -- core request
//   cpu_rdata, cpu_stall                                  -- core response
//   bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata -- bus request
//   bus_addr_ok, bus_data_ok, bus_rdata                   -- bus response
//   dbg_state[1:0]                                        -- FSM state
// -----------------------------------------------------------------------------
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        dbg_state
);

    state_t state, state_nx;

    logic              wr_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [3:0]        wstrb_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;

    logic              fmt_wr;
    logic [1:0]        fmt_size;
    logic [ADDR_W-1:0] fmt_addr;
    logic [3:0]        fmt_strb;

    logic              latch_req;
    logic              capture_rdata;

    dbus_fmt #(.ADDR_W(ADDR_W)) u_fmt (
        .wen      (cpu_wen),
        .addr     (cpu_addr),
        .wr       (fmt_wr),
        .size     (fmt_size),
        .fmt_addr (fmt_addr),
        .strb     (fmt_strb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cpu_stall     = 1'b0;
        cpu_rdata     = rdata_r;
        bus_req       = 1'b0;
        latch_req     = 1'b0;
        capture_rdata = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_stall = cpu_req;
                if (cpu_req) begin
                    latch_req = 1'b1;
                    state_nx  = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req   = 1'b1;
                cpu_stall = 1'b1;
                // A data_ok seen here is not a valid response and is ignored.
                if (bus_addr_ok) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cpu_stall = !bus_data_ok;
                if (bus_data_ok) begin
                    cpu_rdata     = bus_rdata;
                    capture_rdata = 1'b1;
                    // If another source holds the pipeline, park in DONE so
                    // the same M-stage access is not issued a second time.
                    state_nx      = cpu_hold ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!cpu_hold) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_r    <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= '0;
            wstrb_r <= 4'd0;
            wdata_r <= '0;
        end else if (latch_req) begin
            wr_r    <= fmt_wr;
            size_r  <= fmt_size;
            addr_r  <= fmt_addr;
            wstrb_r <= fmt_strb;
            wdata_r <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= '0;
        end else if (capture_rdata) begin
            rdata_r <= bus_rdata;
        end
    end

    assign bus_wr    = wr_r;
    assign bus_size  = size_r;
    assign bus_addr  = addr_r;
    assign bus_wstrb = wstrb_r;
    assign bus_wdata = wdata_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_data_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_sram_bridge
// Self-checking bench for data_sram_bridge: a table of single accesses with
// hand-computed bus formatting, plus directed sequences for load latency,
// held pipeline, slow slave and reset mid-transaction.
// -----------------------------------------------------------------------------
module tb_data_sram_bridge;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_hold;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    data_sram_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_wen     (cpu_wen),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_hold    (cpu_hold),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wstrb   (bus_wstrb),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are then
    // driven, and outputs are sampled one more unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req     = 1'b0;
        cpu_wen     = 4'd0;
        cpu_addr    = 32'd0;
        cpu_wdata   = 32'd0;
        cpu_hold    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{4'b0000, 32'h0000_1004, 32'h1111_1111, 1'b0, 2'd2, 32'h0000_1004, 4'b0000};
        vecs[1]  = '{4'b0100, 32'h0000_2003, 32'h00AB_0000, 1'b1, 2'd0, 32'h0000_2002, 4'b0100};
        vecs[2]  = '{4'b1100, 32'h0000_3000, 32'hBEEF_0000, 1'b1, 2'd1, 32'h0000_3002, 4'b1100};
        vecs[3]  = '{4'b1111, 32'h0000_4007, 32'h0102_0304, 1'b1, 2'd2, 32'h0000_4004, 4'b1111};
        vecs[4]  = '{4'b0011, 32'h0000_5003, 32'h0000_CAFE, 1'b1, 2'd1, 32'h0000_5000, 4'b0011};
        vecs[5]  = '{4'b0001, 32'h0000_6002, 32'h0000_0077, 1'b1, 2'd0, 32'h0000_6000, 4'b0001};
        vecs[6]  = '{4'b1000, 32'h0000_7000, 32'h9900_0000, 1'b1, 2'd0, 32'h0000_7003, 4'b1000};
        vecs[7]  = '{4'b0110, 32'h0000_8002, 32'h00AA_BB00, 1'b1, 2'd2, 32'h0000_8000, 4'b0110};
        vecs[8]  = '{4'b0010, 32'h0000_9000, 32'h0000_5500, 1'b1, 2'd0, 32'h0000_9001, 4'b0010};
`ifdef KSEG_MAP_EN
        vecs[9]  = '{4'b0000, 32'hBFC0_0010, 32'h0,         1'b0, 2'd2, 32'h1FC0_0010, 4'b0000};
`else
        vecs[9]  = '{4'b0000, 32'hBFC0_0010, 32'h0,         1'b0, 2'd2, 32'hBFC0_0010, 4'b0000};
`endif
        vecs[10] = '{4'b0000, 32'hC000_0003, 32'h0,         1'b0, 2'd2, 32'hC000_0000, 4'b0000};
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] resp;
        idle_inputs();
        rst = 1'b0;
        #2;
        // Reset state
        check("rst_state",     dbg_state, S_IDLE);
        check("rst_bus_req",   bus_req,   1'b0);
        check("rst_stall",     cpu_stall, 1'b0);
        check("rst_bus_addr",  bus_addr,  32'd0);
        check("rst_bus_fields", {bus_wr, bus_size, bus_wstrb}, 7'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        repeat (2) step();
        rst = 1'b1;
        step();

        // ---- table: one access per vector, addr_ok and data_ok 1 cycle each
        for (int i = 0; i < 11; i++) begin
            resp = 32'hC0DE_0000 + 32'(i);
            cpu_req   = 1'b1;
            cpu_wen   = vecs[i].wen;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            settle();
            check($sformatf("v%0d_idle_stall", i), cpu_stall, 1'b1);
            check($sformatf("v%0d_idle_req", i), bus_req, 1'b0);
            step();
            bus_addr_ok = 1'b1;
            settle();
            check($sformatf("v%0d_req_state", i), dbg_state, S_REQ);
            check($sformatf("v%0d_bus_req", i), bus_req, 1'b1);
            check($sformatf("v%0d_bus_wr", i), bus_wr, vecs[i].exp_wr);
            check($sformatf("v%0d_bus_size", i), bus_size, vecs[i].exp_size);
            check($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_bus_wstrb", i), bus_wstrb, vecs[i].exp_wstrb);
            check($sformatf("v%0d_bus_wdata", i), bus_wdata, vecs[i].wdata);
            check($sformatf("v%0d_req_stall", i), cpu_stall, 1'b1);
            step();
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b1;
            bus_rdata   = resp;
            settle();
            check($sformatf("v%0d_wait_state", i), dbg_state, S_WAIT);
            check($sformatf("v%0d_wait_bus_req", i), bus_req, 1'b0);
            check($sformatf("v%0d_wait_stall", i), cpu_stall, 1'b0);
            check($sformatf("v%0d_wait_rdata", i), cpu_rdata, resp);
            step();
            idle_inputs();
            bus_rdata = 32'h5A5A_5A5A;
            settle();
            check($sformatf("v%0d_back_idle", i), dbg_state, S_IDLE);
            check($sformatf("v%0d_rdata_r", i), cpu_rdata, resp);
            check($sformatf("v%0d_done_stall", i), cpu_stall, 1'b0);
        end

        // ---- held pipeline: data_ok arrives while cpu_hold=1
        cpu_req = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_1004;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678; cpu_hold = 1'b1;
        settle();
        check("hold_wait_rdata", cpu_rdata, 32'h1234_5678);
        check("hold_wait_stall", cpu_stall, 1'b0);
        step();
        bus_data_ok = 1'b0; bus_rdata = 32'hFFFF_0000;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("hold%0d_state", c), dbg_state, S_DONE);
            check($sformatf("hold%0d_rdata", c), cpu_rdata, 32'h1234_5678);
            check($sformatf("hold%0d_stall", c), cpu_stall, 1'b0);
            check($sformatf("hold%0d_bus_req", c), bus_req, 1'b0);
            if (c < 2) step();
        end
        cpu_hold = 1'b0;
        settle();
        check("hold_release_state", dbg_state, S_DONE);
        step();
        idle_inputs();
        settle();
        check("hold_back_idle", dbg_state, S_IDLE);
        check("hold_back_bus_req", bus_req, 1'b0);

        // ---- slow slave: addr_ok after 5 REQ cycles; cpu_req drops mid-way
        cpu_req = 1'b1; cpu_wen = 4'b1111; cpu_addr = 32'h0000_A000; cpu_wdata = 32'h55AA_55AA;
        step();
        cpu_req = 1'b0; cpu_wdata = 32'h0; cpu_addr = 32'h0; cpu_wen = 4'b0;
        for (int c = 0; c < 5; c++) begin
            // A stray data_ok during REQ must be ignored.
            bus_data_ok = (c == 2);
            settle();
            check($sformatf("slow%0d_state", c), dbg_state, S_REQ);
            check($sformatf("slow%0d_bus_req", c), bus_req, 1'b1);
            check($sformatf("slow%0d_addr", c), bus_addr, 32'h0000_A000);
            check($sformatf("slow%0d_wdata", c), bus_wdata, 32'h55AA_55AA);
            check($sformatf("slow%0d_stall", c), cpu_stall, 1'b1);
            step();
        end
        bus_data_ok = 1'b0;
        bus_addr_ok = 1'b1;
        settle();
        check("slow_accept_req", bus_req, 1'b1);
        step();
        bus_addr_ok = 1'b0;
        settle();
        check("slow_wait_state", dbg_state, S_WAIT);
        check("slow_wait_stall", cpu_stall, 1'b1);
        check("slow_wait_bus_req", bus_req, 1'b0);
        step();
        bus_data_ok = 1'b1; bus_rdata = 32'h0;
        settle();
        check("slow_done_stall", cpu_stall, 1'b0);
        step();
        idle_inputs();
        settle();
        check("slow_back_idle", dbg_state, S_IDLE);

        // ---- async reset while in WAIT
        cpu_req = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_B000;
        step();
        bus_addr_ok = 1'b1;
        step();
        idle_inputs();
        settle();
        check("rstw_pre_state", dbg_state, S_WAIT);
        check("rstw_pre_stall", cpu_stall, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("rstw_state", dbg_state, S_IDLE);
        check("rstw_bus_req", bus_req, 1'b0);
        check("rstw_stall", cpu_stall, 1'b0);
        check("rstw_bus_addr", bus_addr, 32'd0);
        check("rstw_rdata", cpu_rdata, 32'd0);
        step();
        rst = 1'b1;
        step();
        settle();
        check("rstw_after_state", dbg_state, S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Memory-stage data-access bridge sitting directly downstream of the CPU core's M-stage data port.
- Consumes the core's address, write data and 4-bit byte write enables, plus a read/write request.
- Converts them into a split-handshake SRAM-like bus (req/addr_ok/data_ok).
- Returns load data and a stall so the pipeline freezes until the access completes.

Parameters:
- ADDR_W, 32, address width of the CPU and bus sides.
- DATA_W, 32, data width; fixed at 32. Strobe width is DATA_W/8 = 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  M-stage instruction is a load or store (memread | memwrite).
- cpu_wen  in  4  byte write enables; 0000 means read.
- cpu_addr  in  ADDR_W  effective address (aluoutM).
- cpu_wdata  in  DATA_W  store data, already lane-aligned (writedataM).
- cpu_hold  in  1  pipeline held by another stall source this cycle.
- cpu_rdata  out  DATA_W  load data (readdataM).
- cpu_stall  out  1  freeze the pipeline.
- bus_req  out  1  request valid.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_addr  out  ADDR_W  bus address.
- bus_wstrb  out  4  byte strobes.
- bus_wdata  out  DATA_W  write data.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  response valid.
- bus_rdata  in  DATA_W  response data.

Behaviour:
- **FSM states:** IDLE, REQ, WAIT, DONE. Reset value is IDLE.
- **Reset outputs:** bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, cpu_rdata=0, cpu_stall=0. All latched request registers and rdata_r clear to 0.
- **IDLE:**
  - cpu_req=1: latch wr=|cpu_wen, strobes, data and the formatted address/size; go to REQ.
  - cpu_stall=cpu_req, combinational, the same cycle.
- **REQ:**
  - bus_req=1; address, size, strobes and data held stable from the registers; cpu_stall=1.
  - bus_addr_ok=1: go to WAIT. bus_req drops next cycle.
- **WAIT:**
  - bus_req=0; cpu_stall=!bus_data_ok.
  - bus_data_ok=1: cpu_rdata=bus_rdata combinationally that cycle; capture bus_rdata into rdata_r.
  - Next state is DONE if cpu_hold=1, else IDLE.
  - bus_data_ok is never expected in the same cycle as addr_ok. One arriving in REQ is ignored.
- **DONE:**
  - cpu_stall=0; cpu_rdata=rdata_r.
  - Stays in DONE while cpu_hold=1; goes to IDLE when cpu_hold=0, which is the edge the pipeline advances.
  - This prevents re-issuing the same M-stage access while another stall source holds the pipeline.
- **cpu_rdata in other states:** equals rdata_r.
- **Latency:** a load with addr_ok and data_ok each 1 cycle after being awaited costs 3 cycles in M, i.e. 2 stall cycles plus the completing cycle.
- **Reads:** bus_size=2; bus_addr = cpu_addr with [1:0] forced to 00; bus_wstrb=0000. Byte/half extraction is done downstream.
- **Writes:** size and address low bits come from the strobes.
  - 1111 gives size 2, low bits 00.
  - 0011 gives size 1, low bits 00; 1100 gives size 1, low bits 10.
  - One-hot 0001/0010/0100/1000 gives size 0, low bits 00/01/10/11.
  - Any other pattern: size 2, low bits 00, strobes passed through unchanged.
- **No abort:** once REQ is entered the transaction always completes; cpu_req dropping mid-access is ignored.
- **Async reset mid-transaction:** returns to IDLE immediately and drops bus_req. The bus slave is reset by the same signal.

Optional Feature:
- Macro: KSEG_MAP_EN.
- **Defined:** applied to the formatted bus_addr only. Addresses 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) map to physical by ANDing with 0x1FFF_FFFF; all other addresses pass unchanged.
- **Undefined:** bus_addr is never translated.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: IDLE=0, REQ=1, WAIT=2, DONE=3).
  - Size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - KSEG mask constant 32'h1FFF_FFFF.
- One natural sub-module, dbus_fmt: combinational. Maps cpu_wen/cpu_addr to bus_wr, bus_size, bus_addr and bus_wstrb, including the KSEG mapping.

Test Plan:
- Load word: cpu_req=1, wen=0000, addr=0x0000_1004; addr_ok 1 cycle after REQ, data_ok next cycle with 0xDEADBEEF -> bus_addr=0x1004, size=2, wr=0; stall high 2 cycles; cpu_rdata=0xDEADBEEF in the data_ok cycle.
- Byte store: wen=0100, addr=0x0000_2003, wdata=0x00AB0000 -> bus_addr=0x2002, size=0, wstrb=0100, wr=1.
- Half store: wen=1100, addr=0x0000_3000 -> bus_addr=0x3002, size=1.
- Held pipeline: data_ok=1 with cpu_hold=1 for 3 cycles -> FSM in DONE, cpu_rdata stable at the latched value, stall=0, no second bus_req. Returns to IDLE after hold drops.
- Slow slave: addr_ok delayed 5 cycles -> bus_req, addr and wdata stable throughout, stall continuously high.
- Reset asserted in WAIT -> bus_req=0, stall=0, state IDLE immediately. With KSEG_MAP_EN, a load at 0xBFC0_0010 gives bus_addr=0x1FC0_0010.
